// File: rtl/proc_io_bridge_pkg.sv
// Shared definitions for the processor I/O bridge: address regions, timer
// register offsets, control/status bit positions and the read-select record.
package proc_io_bridge_pkg;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_HEX = 4'h2;
    localparam logic [3:0] REG_TMR = 4'h3;

    localparam logic [1:0] TMR_RELOAD = 2'd0;
    localparam logic [1:0] TMR_CTRL   = 2'd1;
    localparam logic [1:0] TMR_STATUS = 2'd2;
    localparam logic [1:0] TMR_COUNT  = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AR_BIT    = 1;
    localparam int STATUS_EXP_BIT = 0;

    // Registered copy of the access selector, used to steer DIN one cycle later.
    typedef struct packed {
        logic [3:0] region;
        logic [1:0] offset;
    } sel_t;

    // A prescaler of 1 still needs a 1-bit counter.
    function automatic int pcnt_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Down-counting timer with prescaler, reload/ctrl/status registers and an
// expired flag that drives the interrupt line.
module io_timer
    import proc_io_bridge_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam int             PW        = pcnt_width(PRESCALE);
    localparam logic [PW-1:0]  PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     pcnt;
    logic [DATA_W-1:0] reload;
    logic [DATA_W-1:0] count;
    logic              en;
    logic              autoreload;
    logic              expired;

    logic tick;
    logic wr_reload;
    logic wr_ctrl;
    logic wr_status;
    logic fire;

    assign tick      = en && (pcnt == PCNT_LAST);
    assign wr_reload = wr_en && (offset == TMR_RELOAD);
    assign wr_ctrl   = wr_en && (offset == TMR_CTRL);
    assign wr_status = wr_en && (offset == TMR_STATUS);
    // A reload write in the same cycle replaces the tick's count update, expiry included.
    assign fire      = tick && !wr_reload && (count == DATA_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            reload     <= '0;
            count      <= '0;
            en         <= 1'b0;
            autoreload <= 1'b0;
            expired    <= 1'b0;
        end else begin
            if (!en || (pcnt == PCNT_LAST)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PW'(1);
            end

            if (wr_reload) begin
                reload <= wdata;
                count  <= wdata;
            end else if (tick && (count != '0)) begin
                if (count == DATA_W'(1)) begin
                    count <= autoreload ? reload : '0;
                end else begin
                    count <= count - DATA_W'(1);
                end
            end

            if (wr_ctrl) begin
                en         <= wdata[CTRL_EN_BIT];
                autoreload <= wdata[CTRL_AR_BIT];
            end

            if (fire) begin
                expired <= 1'b1;
            end else if (wr_status && wdata[STATUS_EXP_BIT]) begin
                expired <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            TMR_RELOAD: rdata = reload;
            TMR_CTRL: begin
                rdata[CTRL_EN_BIT] = en;
                rdata[CTRL_AR_BIT] = autoreload;
            end
            TMR_STATUS: rdata[STATUS_EXP_BIT] = expired;
            TMR_COUNT:  rdata = count;
            default:    rdata = '0;
        endcase
    end

    assign irq = expired;

endmodule

// File: rtl/proc_io_bridge.sv
// Memory-mapped bus stage: decodes processor accesses to RAM, LED, HEX and
// timer, and returns read data with the same 1-cycle latency as the RAM.
module proc_io_bridge
    import proc_io_bridge_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RAM_AW   = 7,
    parameter int PRESCALE = 50000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DOUT,
    input  logic              W,
    output logic [DATA_W-1:0] DIN,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [9:0]        LEDR,
    output logic [DATA_W-1:0] HEX_val,
    output logic              Timer_irq
);

    logic [3:0]        region;
    logic [1:0]        offset;
    logic              tmr_wr;
    logic [DATA_W-1:0] tmr_rdata;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] rd_q;
    sel_t              sel_q;
    logic              unused_bits;

    assign region = ADDR[15:12];
    assign offset = ADDR[1:0];

    // RAM path is purely combinational; the RAM itself provides the read register.
    assign ram_addr = ADDR[RAM_AW-1:0];
    assign ram_data = DOUT;
    assign ram_wren = W && (region == REG_RAM);

    assign tmr_wr = W && (region == REG_TMR);

    io_timer #(
        .DATA_W   (DATA_W),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk    (Clock),
        .rst    (Reset),
        .wr_en  (tmr_wr),
        .offset (offset),
        .wdata  (DOUT),
        .rdata  (tmr_rdata),
        .irq    (Timer_irq)
    );

    always_comb begin
        rd_next = '0;
        case (region)
            REG_LED: rd_next = {{(DATA_W-10){1'b0}}, LEDR};
            REG_HEX: rd_next = HEX_val;
            REG_TMR: rd_next = tmr_rdata;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            LEDR    <= '0;
            HEX_val <= '0;
            sel_q   <= '{region: REG_RAM, offset: 2'd0};
            rd_q    <= '0;
        end else begin
            if (W && (region == REG_LED)) begin
                LEDR <= DOUT[9:0];
            end
            if (W && (region == REG_HEX)) begin
                HEX_val <= DOUT;
            end
            // Read data reflects register state before this edge's writes.
            sel_q <= '{region: region, offset: offset};
            rd_q  <= rd_next;
        end
    end

    assign DIN = (sel_q.region == REG_RAM) ? ram_q : rd_q;

    assign unused_bits = ^{ADDR[11:RAM_AW], sel_q.offset};

endmodule

// File: tb/tb_proc_io_bridge.sv
// Self-checking bench for proc_io_bridge: two instances (PRESCALE 4 and 2)
// share one bus; a behavioural model plus directed tables check both.
module tb_proc_io_bridge;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] ADDR  = '0;
    logic [15:0] DOUT  = '0;
    logic        W     = 1'b0;
    logic [15:0] ram_q;

    logic [15:0] din4, din2, ram_data4, ram_data2, hex4, hex2;
    logic [6:0]  ram_addr4, ram_addr2;
    logic        ram_wren4, ram_wren2, irq4, irq2;
    logic [9:0]  led4, led2;

    always #5 Clock = ~Clock;

    proc_io_bridge #(.DATA_W(16), .ADDR_W(16), .RAM_AW(7), .PRESCALE(4)) u_dut4 (
        .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(din4),
        .ram_addr(ram_addr4), .ram_data(ram_data4), .ram_wren(ram_wren4), .ram_q(ram_q),
        .LEDR(led4), .HEX_val(hex4), .Timer_irq(irq4)
    );

    proc_io_bridge #(.DATA_W(16), .ADDR_W(16), .RAM_AW(7), .PRESCALE(2)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(din2),
        .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_wren(ram_wren2), .ram_q(ram_q),
        .LEDR(led2), .HEX_val(hex2), .Timer_irq(irq2)
    );

    // Synchronous RAM with read-old-data behaviour, driven by the first instance.
    logic [15:0] mem [128] = '{default: '0};
    always @(posedge Clock) begin
        if (ram_wren4) mem[ram_addr4] <= ram_data4;
        ram_q <= mem[ram_addr4];
    end

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state, index 0 = PRESCALE 4, index 1 = PRESCALE 2.
    logic [15:0] m_mem [128] = '{default: '0};
    logic [9:0]  m_led [2];
    logic [15:0] m_hex [2];
    logic [15:0] m_reload [2];
    logic [15:0] m_count [2];
    logic        m_en [2];
    logic        m_ar [2];
    logic        m_exp [2];
    int          m_phase [2];
    logic [15:0] m_din [2];

    logic [15:0] a_din [2];
    logic        a_irq [2];
    logic        pre_wren4;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] dout;
        logic        w;
        logic [15:0] exp_din;
        logic        exp_wren;
        logic [9:0]  exp_led;
        logic [15:0] exp_hex;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input logic rst, input logic [15:0] a, input logic [15:0] d,
                               input logic wr);
        logic [3:0]  rg;
        logic [1:0]  off;
        logic [15:0] rv;
        logic        tick, wr_t, fire;
        int          p;
        rg  = a[15:12];
        off = a[1:0];
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? 4 : 2;
            if (rst) begin
                m_din[i] = m_mem[a[6:0]];
                m_led[i] = '0; m_hex[i] = '0; m_reload[i] = '0; m_count[i] = '0;
                m_en[i] = 1'b0; m_ar[i] = 1'b0; m_exp[i] = 1'b0; m_phase[i] = 0;
            end else begin
                case (rg)
                    4'h0: rv = m_mem[a[6:0]];
                    4'h1: rv = {6'b0, m_led[i]};
                    4'h2: rv = m_hex[i];
                    4'h3: case (off)
                        2'd0: rv = m_reload[i];
                        2'd1: rv = {14'b0, m_ar[i], m_en[i]};
                        2'd2: rv = {15'b0, m_exp[i]};
                        default: rv = m_count[i];
                    endcase
                    default: rv = '0;
                endcase
                m_din[i] = rv;
                tick = m_en[i] && (m_phase[i] == p - 1);
                m_phase[i] = m_en[i] ? (m_phase[i] + 1) % p : 0;
                wr_t = wr && (rg == 4'h3);
                fire = 1'b0;
                if (wr_t && off == 2'd0) begin
                    m_reload[i] = d;
                    m_count[i]  = d;
                end else if (tick && m_count[i] != 0) begin
                    if (m_count[i] == 1) begin
                        fire = 1'b1;
                        m_count[i] = m_ar[i] ? m_reload[i] : 16'd0;
                    end else begin
                        m_count[i] = m_count[i] - 16'd1;
                    end
                end
                if (fire) m_exp[i] = 1'b1;
                else if (wr_t && off == 2'd2 && d[0]) m_exp[i] = 1'b0;
                if (wr_t && off == 2'd1) begin
                    m_en[i] = d[0];
                    m_ar[i] = d[1];
                end
                if (wr && rg == 4'h1) m_led[i] = d[9:0];
                if (wr && rg == 4'h2) m_hex[i] = d;
            end
        end
        if (wr && rg == 4'h0) m_mem[a[6:0]] = d;
    endtask

    // One bus cycle: drive, check the combinational RAM path, advance model and DUTs, compare.
    task automatic step(input logic rst, input logic [15:0] a, input logic [15:0] d,
                        input logic wr);
        Reset = rst; ADDR = a; DOUT = d; W = wr;
        #1;
        pre_wren4 = ram_wren4;
        check("ram_wren4", 32'(ram_wren4), 32'(wr && a[15:12] == 4'h0));
        check("ram_addr4", 32'(ram_addr4), 32'(a[6:0]));
        check("ram_data4", 32'(ram_data4), 32'(d));
        check("ram_wren2", 32'(ram_wren2), 32'(wr && a[15:12] == 4'h0));
        model_cycle(rst, a, d, wr);
        @(posedge Clock);
        #1;
        a_din[0] = din4; a_din[1] = din2;
        a_irq[0] = irq4; a_irq[1] = irq2;
        check("din4", 32'(din4), 32'(m_din[0]));
        check("din2", 32'(din2), 32'(m_din[1]));
        check("led4", 32'(led4), 32'(m_led[0]));
        check("led2", 32'(led2), 32'(m_led[1]));
        check("hex4", 32'(hex4), 32'(m_hex[0]));
        check("hex2", 32'(hex2), 32'(m_hex[1]));
        check("irq4", 32'(irq4), 32'(m_exp[0]));
        check("irq2", 32'(irq2), 32'(m_exp[1]));
    endtask

    initial begin
        logic [15:0] ra, rd;
        logic        rw, rr;

        tbl[0] = '{16'h0007, 16'd12,    1'b1, 16'd0,     1'b1, 10'h000, 16'd0};
        tbl[1] = '{16'h0007, 16'd0,     1'b0, 16'd12,    1'b0, 10'h000, 16'd0};
        tbl[2] = '{16'h1000, 16'h03FF,  1'b1, 16'd0,     1'b0, 10'h3FF, 16'd0};
        tbl[3] = '{16'h2000, 16'd56,    1'b1, 16'd0,     1'b0, 10'h3FF, 16'd56};
        tbl[4] = '{16'h1000, 16'd0,     1'b0, 16'h03FF,  1'b0, 10'h3FF, 16'd56};
        tbl[5] = '{16'h5000, 16'd0,     1'b0, 16'd0,     1'b0, 10'h3FF, 16'd56};
        tbl[6] = '{16'h2000, 16'd0,     1'b0, 16'd56,    1'b0, 10'h3FF, 16'd56};
        tbl[7] = '{16'h5000, 16'h1234,  1'b1, 16'd0,     1'b0, 10'h3FF, 16'd56};
        tbl[8] = '{16'h0007, 16'd0,     1'b0, 16'd12,    1'b0, 10'h3FF, 16'd56};
        tbl[9] = '{16'hF0FF, 16'd0,     1'b0, 16'd0,     1'b0, 10'h3FF, 16'd56};

        // Reset clears pre-written LED/HEX registers.
        step(1'b1, 16'h0000, 16'd0, 1'b0);
        step(1'b0, 16'h1000, 16'h02A5, 1'b1);
        step(1'b0, 16'h2000, 16'hBEEF, 1'b1);
        step(1'b1, 16'h0000, 16'd0, 1'b0);
        check("rst_led", 32'(led4), 32'd0);
        check("rst_hex", 32'(hex4), 32'd0);
        check("rst_irq", 32'(irq4), 32'd0);
        step(1'b0, 16'h3003, 16'd0, 1'b0);
        check("rst_count", 32'(a_din[0]), 32'd0);

        // RAM / LED / HEX / unmapped table.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].addr, tbl[i].dout, tbl[i].w);
            check($sformatf("tbl%0d_wren", i), 32'(pre_wren4), 32'(tbl[i].exp_wren));
            check($sformatf("tbl%0d_din", i), 32'(a_din[0]), 32'(tbl[i].exp_din));
            check($sformatf("tbl%0d_led", i), 32'(led4), 32'(tbl[i].exp_led));
            check($sformatf("tbl%0d_hex", i), 32'(hex4), 32'(tbl[i].exp_hex));
        end

        // One-shot timer on the PRESCALE=4 instance.
        step(1'b1, 16'h0000, 16'd0, 1'b0);
        step(1'b0, 16'h3000, 16'd3, 1'b1);
        step(1'b0, 16'h3001, 16'd1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 16'h3003, 16'd0, 1'b0);
            check($sformatf("oneshot_irq_k%0d", k), 32'(a_irq[0]), 32'(k == 12));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 16'h3003, 16'd0, 1'b0);
            check("oneshot_count0", 32'(a_din[0]), 32'd0);
            check("oneshot_irq_hold", 32'(a_irq[0]), 32'd1);
        end
        step(1'b0, 16'h3002, 16'd0, 1'b0);
        check("oneshot_status", 32'(a_din[0]), 32'd1);

        // Autoreload on the PRESCALE=2 instance, with clear colliding with expiry.
        step(1'b1, 16'h0000, 16'd0, 1'b0);
        step(1'b0, 16'h3000, 16'd2, 1'b1);
        step(1'b0, 16'h3001, 16'd3, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            rw = (k == 8 || k == 9);
            step(1'b0, 16'h3002, rw ? 16'd1 : 16'd0, rw);
            check($sformatf("auto_irq_k%0d", k), 32'(a_irq[1]),
                  32'((k >= 4 && k <= 8) || k >= 12));
        end

        // Reset in the middle of a running count.
        step(1'b1, 16'h0000, 16'd0, 1'b0);
        step(1'b0, 16'h3000, 16'd5, 1'b1);
        step(1'b0, 16'h3001, 16'd1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 16'h3003, 16'd0, 1'b0);
        step(1'b1, 16'h3003, 16'd0, 1'b0);
        step(1'b0, 16'h3003, 16'd0, 1'b0);
        check("midrst_count4", 32'(a_din[0]), 32'd0);
        check("midrst_count2", 32'(a_din[1]), 32'd0);
        step(1'b0, 16'h3001, 16'd0, 1'b0);
        check("midrst_ctrl", 32'(a_din[0]), 32'd0);
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 16'h3003, 16'd0, 1'b0);
            check("midrst_noirq", 32'({a_irq[0], a_irq[1]}), 32'd0);
        end

        // Randomized traffic against the model.
        step(1'b1, 16'h0000, 16'd0, 1'b0);
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 5))
                0: ra = {4'h0, 12'($urandom)};
                1: ra = {4'h1, 12'($urandom)};
                2: ra = {4'h2, 12'($urandom)};
                3, 4: ra = {4'h3, 12'($urandom)};
                default: ra = {4'($urandom_range(4, 15)), 12'($urandom)};
            endcase
            rw = ($urandom_range(0, 2) == 0);
            rd = 16'($urandom);
            if (ra[15:12] == 4'h3 && ra[1:0] == 2'd0) rd = 16'($urandom_range(0, 6));
            if (ra[15:12] == 4'h3 && ra[1:0] == 2'd1) rd = 16'($urandom_range(0, 3) | 1);
            rr = ($urandom_range(0, 99) == 0);
            step(rr, ra, rd, rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
